uart_rx: RTL and testbench

- 16x-oversampling UART receiver, the downstream counterpart of uart_tx; it consumes the serial line that uart_tx drives.
- Shares the s_tick strobe from uart_sampling_tick.
- Recovers LSB-first frames of 1 start bit, DATA_SIZE data bits and 1 stop bit.
- Presents each byte with a one-cycle done strobe and a framing-error flag for the downstream RX FIFO.

---
 rtl/uart_rx.sv | 164 ++++++++++++++++
 tb/tb_uart_rx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: 1 start, DATA_SIZE data (LSB first), 1 stop bit.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting on data and stop bits.
module uart_rx #(
  parameter int unsigned DATA_SIZE      = 8,
  parameter int unsigned SAMPLE         = 16,
  parameter int unsigned STOP_TICKS     = 16,
  parameter int unsigned BIT_COUNT_SIZE = $clog2(DATA_SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic                 rx,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 rx_done_tick,
  output logic                 frame_err
);

  localparam int unsigned CNT_MAX = (SAMPLE > STOP_TICKS) ? SAMPLE : STOP_TICKS;
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          s_cnt_q, s_cnt_d;
  logic [BIT_COUNT_SIZE-1:0] n_q, n_d;
  logic [DATA_SIZE-1:0]      shreg_q, shreg_d;
  logic [DATA_SIZE-1:0]      data_q, data_d;
  logic                      done_q, done_d;
  logic                      ferr_q, ferr_d;
  logic                      rx_meta_q, rx_sync_q, rx_prev_q;
  logic                      bit_c;

  assign data_out     = data_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;

`ifdef UART_RX_MAJORITY_EN
  logic samp0_q, samp0_d, samp1_q, samp1_d;

  // Vote the two earlier captures with the live synchronized sample.
  assign bit_c = (samp0_q & samp1_q) | (samp0_q & rx_sync_q) | (samp1_q & rx_sync_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp0_q <= 1'b0;
      samp1_q <= 1'b0;
    end else begin
      samp0_q <= samp0_d;
      samp1_q <= samp1_d;
    end
  end

  always_comb begin
    samp0_d = samp0_q;
    samp1_d = samp1_q;
    if (s_tick) begin
      if (state_q == DATA) begin
        if (s_cnt_q == CNT_W'(SAMPLE - 3)) samp0_d = rx_sync_q;
        if (s_cnt_q == CNT_W'(SAMPLE - 2)) samp1_d = rx_sync_q;
      end else if (state_q == STOP) begin
        if (s_cnt_q == CNT_W'(STOP_TICKS - 3)) samp0_d = rx_sync_q;
        if (s_cnt_q == CNT_W'(STOP_TICKS - 2)) samp1_d = rx_sync_q;
      end
    end
  end
`else
  assign bit_c = rx_sync_q;
`endif

  // Synchronizer and edge-detect pipeline; idle-high after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_q     <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_q     <= n_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_d     = n_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // Only a real high-to-low transition arms; a held-low line does not.
        if (rx_prev_q && !rx_sync_q) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt_q == CNT_W'(SAMPLE / 2 - 1)) begin
            if (!rx_sync_q) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == CNT_W'(SAMPLE - 1)) begin
            s_cnt_d = '0;
            shreg_d = {bit_c, shreg_q[DATA_SIZE-1:1]};
            if (n_q == BIT_COUNT_SIZE'(DATA_SIZE - 1)) state_d = STOP;
            else                                       n_d = n_q + BIT_COUNT_SIZE'(1);
          end else begin
            s_cnt_d = s_cnt_q + CNT_W'(1);
          end
        end
      end
      STOP: begin
        // Leaves mid stop bit so a back-to-back start edge is still seen.
        if (s_tick) begin
          if (s_cnt_q == CNT_W'(STOP_TICKS - 1)) begin
            data_d  = shreg_q;
            ferr_d  = ~bit_c;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_cnt_d = s_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: tick-accurate serial driver and a frame-level
// model (byte in, {frame_err, byte} out). Honours UART_RX_MAJORITY_EN.
module tb_uart_rx;

  localparam int DVSR        = 4;
  localparam int BIT_TICKS   = 16;
  localparam int FRAME_TICKS = 10 * BIT_TICKS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       rx_done_tick;
  logic       frame_err;

  int         tests_run = 0;
  int         tests_failed = 0;
  int         div = 0;
  int         width_err = 0;
  logic       prev_done = 1'b0;
  logic [8:0] obs_q[$];

  uart_rx dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx),
    .data_out     (data_out),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    div    = (div == DVSR - 1) ? 0 : div + 1;
    s_tick = (div == DVSR - 1);
  end

  // Record every delivered word and flag any pulse wider than one clock.
  always @(negedge clk) begin
    if (rx_done_tick === 1'b1) begin
      obs_q.push_back({frame_err, data_out});
      if (prev_done) width_err++;
    end
    prev_done = rx_done_tick;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic wait_tick();
    do @(posedge clk); while (s_tick !== 1'b1);
    #1;
  endtask

  task automatic idle_ticks(input int n, input logic lvl);
    rx = lvl;
    repeat (n) wait_tick();
  endtask

  // Drives one frame tick by tick; tick period 'glitch' is inverted (-1 = none).
  task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int k = 0; k < FRAME_TICKS; k++) begin
      rx = bits[4'(k / BIT_TICKS)] ^ logic'(k == glitch);
      wait_tick();
    end
  endtask

  function automatic logic [8:0] model_word(input logic [7:0] d, input logic stop);
    return {~stop, d};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (data_out !== 8'h00) begin tests_failed++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    tests_run++;
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    tests_run++;
    if (rx_done_tick !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", rx_done_tick); end
    reset = 1'b0;
    idle_ticks(4, 1'b1);
    obs_q.delete();
  endtask

  task automatic test_single_frame();
    obs_q.delete();
    width_err = 0;
    send_frame(8'hCB, 1'b1, -1);
    idle_ticks(8, 1'b1);
    tests_run++;
    if (obs_q.size() != 1) begin tests_failed++; $display("FAIL single_count got=%0d exp=1", obs_q.size()); end
    else begin
      tests_run++;
      if (obs_q[0] !== model_word(8'hCB, 1'b1)) begin
        tests_failed++; $display("FAIL single_word got=%h exp=%h", obs_q[0], model_word(8'hCB, 1'b1));
      end
    end
    tests_run++;
    if (width_err != 0) begin tests_failed++; $display("FAIL single_pulse_width wide_pulses=%0d exp=0", width_err); end
  endtask

  task automatic test_glitch_reject();
    obs_q.delete();
    idle_ticks(4, 1'b0);
    idle_ticks(40, 1'b1);
    tests_run++;
    if (obs_q.size() != 0) begin tests_failed++; $display("FAIL glitch_no_pulse got=%0d exp=0", obs_q.size()); end
    send_frame(8'h3C, 1'b1, -1);
    idle_ticks(8, 1'b1);
    tests_run++;
    if (obs_q.size() != 1) begin tests_failed++; $display("FAIL glitch_next_count got=%0d exp=1", obs_q.size()); end
    else begin
      tests_run++;
      if (obs_q[0] !== model_word(8'h3C, 1'b1)) begin
        tests_failed++; $display("FAIL glitch_next_word got=%h exp=%h", obs_q[0], model_word(8'h3C, 1'b1));
      end
    end
  endtask

  task automatic test_break();
    obs_q.delete();
    send_frame(8'h55, 1'b0, -1);
    idle_ticks(20 * BIT_TICKS, 1'b0);
    tests_run++;
    if (obs_q.size() != 1) begin tests_failed++; $display("FAIL break_count got=%0d exp=1", obs_q.size()); end
    else begin
      tests_run++;
      if (obs_q[0] !== model_word(8'h55, 1'b0)) begin
        tests_failed++; $display("FAIL break_word got=%h exp=%h", obs_q[0], model_word(8'h55, 1'b0));
      end
    end
    idle_ticks(2 * BIT_TICKS, 1'b1);
    obs_q.delete();
    send_frame(8'h81, 1'b1, -1);
    idle_ticks(8, 1'b1);
    tests_run++;
    if (obs_q.size() != 1) begin tests_failed++; $display("FAIL break_recover_count got=%0d exp=1", obs_q.size()); end
    else begin
      tests_run++;
      if (obs_q[0] !== model_word(8'h81, 1'b1)) begin
        tests_failed++; $display("FAIL break_recover_word got=%h exp=%h", obs_q[0], model_word(8'h81, 1'b1));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_q[$];
    logic [7:0] stream[$];
    for (int i = 0; i < 4; i++) stream.push_back(8'($urandom_range(0, 255)));
    stream.push_back(8'h00);
    stream.push_back(8'hFF);
    stream.push_back(8'hA5);
    obs_q.delete();
    foreach (stream[i]) begin
      exp_q.push_back(model_word(stream[i], 1'b1));
      send_frame(stream[i], 1'b1, -1);
    end
    idle_ticks(8, 1'b1);
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL b2b_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests_run++;
        if (obs_q[i] !== exp_q[i]) begin
          tests_failed++; $display("FAIL b2b_word[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] bits;
    bits = {1'b1, 8'h3E, 1'b0};
    obs_q.delete();
    // Stop in the middle of data bit 4.
    for (int k = 0; k < 5 * BIT_TICKS + BIT_TICKS / 2; k++) begin
      rx = bits[4'(k / BIT_TICKS)];
      wait_tick();
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (data_out !== 8'h00) begin tests_failed++; $display("FAIL midrst_data_out got=%h exp=00", data_out); end
    tests_run++;
    if (frame_err !== 1'b0 || rx_done_tick !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_flags got=%b%b exp=00", frame_err, rx_done_tick);
    end
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_tick();
    idle_ticks(3 * BIT_TICKS, 1'b1);
    tests_run++;
    if (obs_q.size() != 0) begin tests_failed++; $display("FAIL midrst_no_pulse got=%0d exp=0", obs_q.size()); end
    send_frame(8'hA5, 1'b1, -1);
    idle_ticks(8, 1'b1);
    tests_run++;
    if (obs_q.size() != 1) begin tests_failed++; $display("FAIL midrst_next_count got=%0d exp=1", obs_q.size()); end
    else begin
      tests_run++;
      if (obs_q[0] !== model_word(8'hA5, 1'b1)) begin
        tests_failed++; $display("FAIL midrst_next_word got=%h exp=%h", obs_q[0], model_word(8'hA5, 1'b1));
      end
    end
  endtask

  task automatic test_sample_glitch();
    logic [7:0] exp_d;
`ifdef UART_RX_MAJORITY_EN
    exp_d = 8'h0F;
`else
    exp_d = 8'h0B;
`endif
    obs_q.delete();
    // Invert only the tick period ending at the centre sample of data bit 2.
    send_frame(8'h0F, 1'b1, 3 * BIT_TICKS + BIT_TICKS / 2 - 1);
    idle_ticks(8, 1'b1);
    tests_run++;
    if (obs_q.size() != 1) begin tests_failed++; $display("FAIL sample_glitch_count got=%0d exp=1", obs_q.size()); end
    else begin
      tests_run++;
      if (obs_q[0] !== model_word(exp_d, 1'b1)) begin
        tests_failed++; $display("FAIL sample_glitch_word got=%h exp=%h", obs_q[0], model_word(exp_d, 1'b1));
      end
    end
  endtask

  task automatic test_random();
    logic [8:0] exp_q[$];
    logic [7:0] d;
    logic       stop;
    int         gap;
    obs_q.delete();
    width_err = 0;
    for (int i = 0; i < 12; i++) begin
      d    = 8'($urandom_range(0, 255));
      stop = 1'($urandom_range(0, 1));
      exp_q.push_back(model_word(d, stop));
      send_frame(d, stop, -1);
      // A low stop bit needs the line to go high again before the next start edge.
      gap = stop ? int'($urandom_range(0, 40)) : int'($urandom_range(1, 40));
      idle_ticks(gap, 1'b1);
    end
    idle_ticks(8, 1'b1);
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL random_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests_run++;
        if (obs_q[i] !== exp_q[i]) begin
          tests_failed++; $display("FAIL random_word[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    tests_run++;
    if (width_err != 0) begin tests_failed++; $display("FAIL random_pulse_width wide_pulses=%0d exp=0", width_err); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_glitch_reject();
    test_break();
    test_back_to_back();
    test_reset_mid_frame();
    test_sample_glitch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
